decap_meta: RTL and testbench

DECAP_META -- requirements
Module: decap_meta

---
 rtl/decap_meta.sv | 184 ++++++++++++++++++
 tb/tb_decap_meta.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decap_meta.sv
// decap_meta: removes a configurable run of shift units from a sliced metadata
// stream. The removed field is reported on o_decapField. The remainder of the
// packet is closed up, pulling units forward from the following slice.
// Two-cycle pipeline: stage 1 holds the current slice while the input port
// shows the next one, and stage 2 registers the rebuilt slice.

module decap_meta #(
    parameter int unsigned META_WIDTH  = 256,
    parameter int unsigned SHIFT_WIDTH = 16,
    parameter int unsigned DECAP_WIDTH = 128,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    input  logic [3:0]                      i_metaSliceOffset,
    input  logic [3:0]                      i_metaDataOffset,
    input  logic [3:0]                      i_decapLength,
    input  logic                            i_decapEn,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic [DECAP_WIDTH-1:0]          o_decapField,
    output logic                            o_decapValid,
    output logic                            o_decapErr
);

    localparam int MW        = int'(META_WIDTH);
    localparam int SW        = int'(SHIFT_WIDTH);
    localparam int DW        = int'(DECAP_WIDTH);
    localparam int UNITS     = MW / SW;
    localparam int MAXU      = DW / SW;
    localparam int START_BIT = MW + int'(TAG_WIDTH) - 1;
    localparam int VALID_BIT = MW + int'(TAG_WIDTH) - 2;
    localparam int TAIL_BIT  = MW + int'(TAG_WIDTH) - 3;

    // Input side decode
    logic       in_start, in_valid, in_tail;
    logic [3:0] in_idx;
    logic [3:0] cnt_q, cnt_d;

    // Config latched on START, and the effective config for the incoming slice
    logic [3:0] cfg_soff_q, cfg_off_q, cfg_len_q;
    logic       cfg_act_q, cfg_act_d;
    logic [3:0] eff_soff, eff_off, eff_len;
    logic       eff_act, eff_err;

    // Stage 1: current slice with its own copy of the config
    logic [META_WIDTH+TAG_WIDTH-1:0] s1_meta_q;
    logic [3:0]                      s1_idx_q, s1_soff_q, s1_off_q, s1_len_q;
    logic                            s1_act_q, s1_err_q;

    // Stage 2 next-state
    logic [SHIFT_WIDTH-1:0]          cur_u [UNITS];
    logic [SHIFT_WIDTH-1:0]          nxt_u [UNITS];
    logic [SHIFT_WIDTH-1:0]          out_u [UNITS];
    logic [SHIFT_WIDTH-1:0]          fld_u [MAXU];
    logic                            s1_valid, s1_tail, mod, at_off, nxt_ok;
    int                              off_i, len_i;
    logic [META_WIDTH-1:0]           data_d;
    logic [DECAP_WIDTH-1:0]          field_d;

    // Output registers
    logic [META_WIDTH+TAG_WIDTH-1:0] meta_q;
    logic [DECAP_WIDTH-1:0]          field_q;
    logic                            dv_q, err_q;

    // Decode the incoming tag, pick the config that applies to this slice,
    // and advance the slice counter.
    always_comb begin
        in_start = i_meta[START_BIT];
        in_valid = i_meta[VALID_BIT];
        in_tail  = i_meta[TAIL_BIT];
        eff_soff = cfg_soff_q;
        eff_off  = cfg_off_q;
        eff_len  = cfg_len_q;
        eff_act  = cfg_act_q;
        eff_err  = 1'b0;
        if (in_start) begin
            eff_soff = i_metaSliceOffset;
            eff_off  = i_metaDataOffset;
            eff_len  = i_decapLength;
            eff_act  = i_decapEn && (i_decapLength != 4'd0)
                       && (int'(i_decapLength) <= MAXU)
                       && (int'(i_metaDataOffset) + int'(i_decapLength) <= UNITS);
            eff_err  = i_decapEn && ((int'(i_decapLength) > MAXU)
                       || (int'(i_metaDataOffset) + int'(i_decapLength) > UNITS));
        end
        in_idx = in_start ? 4'd0 : cnt_q;
        if (!in_valid) begin
            cnt_d = 4'd0;
        end else if (in_idx == 4'hF) begin
            cnt_d = 4'hF;
        end else begin
            cnt_d = in_idx + 4'd1;
        end
        // Stop modifying once the packet's TAIL has gone by
        cfg_act_d = eff_act && !(in_valid && in_tail);
    end

    // Counter, latched config and stage-1 pipeline registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            cfg_soff_q <= '0;
            cfg_off_q  <= '0;
            cfg_len_q  <= '0;
            cfg_act_q  <= 1'b0;
            s1_meta_q  <= '0;
            s1_idx_q   <= '0;
            s1_soff_q  <= '0;
            s1_off_q   <= '0;
            s1_len_q   <= '0;
            s1_act_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cfg_soff_q <= eff_soff;
            cfg_off_q  <= eff_off;
            cfg_len_q  <= eff_len;
            cfg_act_q  <= cfg_act_d;
            s1_meta_q  <= i_meta;
            s1_idx_q   <= in_idx;
            s1_soff_q  <= eff_soff;
            s1_off_q   <= eff_off;
            s1_len_q   <= eff_len;
            s1_act_q   <= eff_act;
            s1_err_q   <= eff_err;
        end
    end

    // Rebuild the stage-1 slice: close the gap and pull units from the next slice
    always_comb begin
        s1_valid = s1_meta_q[VALID_BIT];
        s1_tail  = s1_meta_q[TAIL_BIT];
        mod      = s1_act_q && s1_valid && (s1_idx_q >= s1_soff_q);
        at_off   = mod && (s1_idx_q == s1_soff_q);
        off_i    = at_off ? int'(s1_off_q) : 0;
        len_i    = int'(s1_len_q);
        // Never borrow across a packet boundary
        nxt_ok   = !s1_tail && in_valid && !in_start;
        data_d   = '0;
        field_d  = '0;
        for (int u = 0; u < UNITS; u++) begin
            cur_u[u] = s1_meta_q[MW-1-u*SW -: SW];
            nxt_u[u] = i_meta[MW-1-u*SW -: SW];
        end
        for (int u = 0; u < UNITS; u++) begin
            if (!mod || u < off_i) begin
                out_u[u] = cur_u[u];
            end else if (u < UNITS - len_i) begin
                out_u[u] = cur_u[u+len_i];
            end else begin
                out_u[u] = nxt_ok ? nxt_u[u-(UNITS-len_i)] : '0;
            end
            data_d[MW-1-u*SW -: SW] = out_u[u];
        end
        for (int k = 0; k < MAXU; k++) begin
            fld_u[k] = (at_off && k < len_i) ? cur_u[int'(s1_off_q)+k] : '0;
            field_d[DW-1-k*SW -: SW] = fld_u[k];
        end
    end

    // Output registers; the field is held until the next extraction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q  <= '0;
            field_q <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= {s1_meta_q[MW+int'(TAG_WIDTH)-1:MW], data_d};
            dv_q    <= at_off;
            err_q   <= s1_err_q;
            if (at_off) begin
                field_q <= field_d;
            end
        end
    end

    assign o_meta       = meta_q;
    assign o_decapField = field_q;
    assign o_decapValid = dv_q;
    assign o_decapErr   = err_q;

endmodule

// File: tb/tb_decap_meta.sv
// Scoreboard bench for decap_meta: directed packets push expected output
// slices; a monitor pops and compares whenever a valid slice or pulse appears.

module tb_decap_meta;

    localparam int MW = 256;
    localparam int TW = 8;
    localparam int DW = 128;

    typedef logic [0:15][15:0] slice_t;
    typedef struct {
        logic [MW+TW-1:0] meta;
        logic             dv;
        logic             err;
        logic [DW-1:0]    field;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [MW+TW-1:0] i_meta;
    logic [3:0]       i_metaSliceOffset, i_metaDataOffset, i_decapLength;
    logic             i_decapEn;
    logic [MW+TW-1:0] o_meta;
    logic [DW-1:0]    o_decapField;
    logic             o_decapValid, o_decapErr;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 i_clk = ~i_clk;

    decap_meta dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_meta           (i_meta),
        .i_metaSliceOffset(i_metaSliceOffset),
        .i_metaDataOffset (i_metaDataOffset),
        .i_decapLength    (i_decapLength),
        .i_decapEn        (i_decapEn),
        .o_meta           (o_meta),
        .o_decapField     (o_decapField),
        .o_decapValid     (o_decapValid),
        .o_decapErr       (o_decapErr)
    );

    task automatic chk(input string name, input logic [MW+TW-1:0] act,
                       input logic [MW+TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Unit u of packet-slice id p carries {p, u}
    function automatic logic [15:0] uv(int p, int u);
        logic [7:0] pb, ub;
        pb = p[7:0];
        ub = u[7:0];
        return {pb, ub};
    endfunction

    function automatic slice_t sl(int p);
        slice_t s;
        for (int u = 0; u < 16; u++) s[u] = uv(p, u);
        return s;
    endfunction

    task automatic drive(input logic [7:0] tag, input slice_t d, input int soff,
                         input int off, input int len, input int en);
        i_meta            = {tag, d};
        i_metaSliceOffset = soff[3:0];
        i_metaDataOffset  = off[3:0];
        i_decapLength     = len[3:0];
        i_decapEn         = en[0];
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_meta = '0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] tag, input slice_t d, input logic dv,
                        input logic err, input logic [DW-1:0] f);
        exp_t e;
        e.meta  = {tag, d};
        e.dv    = dv;
        e.err   = err;
        e.field = f;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_meta"}, o_meta, '0);
        chk({name, "_field"}, 264'(o_decapField), '0);
        chk({name, "_valid"}, 264'(o_decapValid), '0);
        chk({name, "_err"}, 264'(o_decapErr), '0);
    endtask

    // Monitor: any valid slice or pulse must match the next expected item
    always @(negedge i_clk) begin
        if (i_rst_n && (o_meta[MW+TW-2] || o_decapValid || o_decapErr)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h dv=%b err=%b expected nothing",
                         o_meta, o_decapValid, o_decapErr);
            end else begin
                mon_e = q.pop_front();
                chk("meta", o_meta, mon_e.meta);
                chk("decap_valid", 264'(o_decapValid), 264'(mon_e.dv));
                chk("decap_err", 264'(o_decapErr), 264'(mon_e.err));
                if (mon_e.dv) chk("decap_field", 264'(o_decapField), 264'(mon_e.field));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        slice_t e0, e1, e2;
        logic [0:7][15:0] fld;
        int tc_en[3], tc_len[3], tc_soff[3], tc_n[3];

        i_rst_n = 1'b0;
        i_meta = {8'hEA, sl(8'h77)};
        i_metaSliceOffset = 4'd1;
        i_metaDataOffset = 4'd2;
        i_decapLength = 4'd3;
        i_decapEn = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk_zero("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(3);

        // Single START|TAIL slice, off=2 len=3
        for (int u = 0; u < 16; u++) e0[u] = (u < 2) ? uv(0, u) : (u < 13) ? uv(0, u + 3) : 16'h0;
        push(8'hEA, e0, 1'b1, 1'b0, {16'h0002, 16'h0003, 16'h0004, 80'h0});
        drive(8'hEA, sl(0), 0, 2, 3, 1);
        idle(5);
        chk("field_hold", 264'(o_decapField), 264'({16'h0002, 16'h0003, 16'h0004, 80'h0}));

        // 3 slices, sliceOff=1 off=0 len=8; non-START config is ignored
        for (int u = 0; u < 16; u++) begin
            e1[u] = (u < 8) ? uv(8'h11, u + 8) : uv(8'h12, u - 8);
            e2[u] = (u < 8) ? uv(8'h12, u + 8) : 16'h0;
        end
        for (int k = 0; k < 8; k++) fld[k] = uv(8'h11, k);
        push(8'hC3, sl(8'h10), 1'b0, 1'b0, '0);
        push(8'h41, e1, 1'b1, 1'b0, fld);
        push(8'h62, e2, 1'b0, 1'b0, '0);
        drive(8'hC3, sl(8'h10), 1, 0, 8, 1);
        drive(8'h41, sl(8'h11), 0, 3, 2, 0);
        drive(8'h62, sl(8'h12), 0, 3, 2, 0);
        idle(4);

        // Illegal config off=12 len=6: unchanged, one error pulse
        push(8'hC0, sl(8'h20), 1'b0, 1'b1, '0);
        push(8'h60, sl(8'h21), 1'b0, 1'b0, '0);
        drive(8'hC0, sl(8'h20), 0, 12, 6, 1);
        drive(8'h60, sl(8'h21), 0, 12, 6, 1);
        idle(4);

        // Back-to-back packets, TAIL then START on the next cycle
        for (int u = 0; u < 16; u++) begin
            e0[u] = (u < 4) ? uv(8'h30, u) : (u < 14) ? uv(8'h30, u + 2) : uv(8'h31, u - 14);
            e1[u] = (u < 14) ? uv(8'h31, u + 2) : 16'h0;
            e2[u] = (u < 14) ? uv(8'h41, u) : 16'h0;
        end
        push(8'hC0, e0, 1'b1, 1'b0, {uv(8'h30, 4), uv(8'h30, 5), 96'h0});
        push(8'h60, e1, 1'b0, 1'b0, '0);
        push(8'hC0, sl(8'h40), 1'b0, 1'b0, '0);
        push(8'h60, e2, 1'b1, 1'b0, {uv(8'h41, 14), uv(8'h41, 15), 96'h0});
        drive(8'hC0, sl(8'h30), 0, 4, 2, 1);
        drive(8'h60, sl(8'h31), 0, 4, 2, 1);
        drive(8'hC0, sl(8'h40), 1, 14, 2, 1);
        drive(8'h60, sl(8'h41), 1, 14, 2, 1);
        idle(4);

        // Pass-through cases: en=0, len=0, TAIL before sliceOffset
        tc_en   = '{0, 1, 1};
        tc_len  = '{3, 0, 2};
        tc_soff = '{0, 0, 3};
        tc_n    = '{4, 4, 2};
        for (int t = 0; t < 3; t++) begin
            for (int s = 0; s < tc_n[t]; s++) begin
                logic [7:0] tg;
                tg = 8'h40 | ((s == 0) ? 8'h80 : 8'h00) | ((s == tc_n[t] - 1) ? 8'h20 : 8'h00);
                push(tg, sl(8'h50 + t * 4 + s), 1'b0, 1'b0, '0);
            end
            for (int s = 0; s < tc_n[t]; s++) begin
                logic [7:0] tg;
                tg = 8'h40 | ((s == 0) ? 8'h80 : 8'h00) | ((s == tc_n[t] - 1) ? 8'h20 : 8'h00);
                drive(tg, sl(8'h50 + t * 4 + s), tc_soff[t], 1, tc_len[t], tc_en[t]);
            end
            idle(3);
        end

        // Reset pulse mid-packet; the slice after reset passes unmodified
        drive(8'hC0, sl(8'h70), 0, 0, 1, 1);
        drive(8'h40, sl(8'h71), 0, 0, 1, 1);
        i_rst_n = 1'b0;
        i_meta = {8'h40, sl(8'h72)};
        @(negedge i_clk);
        chk_zero("mid_reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        push(8'h60, sl(8'h73), 1'b0, 1'b0, '0);
        drive(8'h60, sl(8'h73), 0, 0, 1, 1);
        idle(4);

        // Fresh packet after reset decapsulates again
        for (int u = 0; u < 16; u++) e0[u] = (u < 15) ? uv(8'h60, u + 1) : 16'h0;
        push(8'hE0, e0, 1'b1, 1'b0, {uv(8'h60, 0), 112'h0});
        drive(8'hE0, sl(8'h60), 0, 0, 1, 1);
        idle(6);

        chk("queue_empty", 264'(q.size()), 264'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
